// File: rtl/jt51_out_pkg.sv
// Shared types and widths for the JT51 audio output path.
package jt51_out_pkg;

    localparam int SMP_W     = 16;
    localparam int SDM_ACC_W = 17;

    typedef logic signed [SMP_W-1:0] sample_t;

    typedef struct packed {
        sample_t l;
        sample_t r;
    } stereo_t;

endpackage

// File: rtl/jt51_sdm.sv
// One channel of a first-order sigma-delta modulator; dac is the accumulator carry.
module jt51_sdm
    import jt51_out_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  sample_t s,
    output logic    dac
);

    logic [SDM_ACC_W-1:0] acc_q, acc_d;
    logic [SMP_W-1:0]     u;

    // Offset-binary: flipping the sign bit maps -32768..32767 onto 0..65535.
    always_comb begin
        u     = {~s[SMP_W-1], s[SMP_W-2:0]};
        acc_d = {1'b0, acc_q[SMP_W-1:0]} + {1'b0, u};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end

    assign dac = acc_q[SDM_ACC_W-1];

endmodule

// File: rtl/jt51_sample_fifo.sv
// Stereo sample FIFO between the JT51 accumulator and the audio sink, with sticky overflow.
// Define JT51_SAMPLE_SDM_EN to add 1-bit sigma-delta outputs dac_left/dac_right.
module jt51_sample_fifo
    import jt51_out_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int USE_EXACT = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sample,
    input  sample_t                left,
    input  sample_t                right,
    input  sample_t                xleft,
    input  sample_t                xright,
    output logic                   out_valid,
    input  logic                   out_ready,
    output sample_t                out_left,
    output sample_t                out_right,
    output logic [$clog2(DEPTH):0] level,
    output logic                   ovf,
    input  logic                   ovf_clr
`ifdef JT51_SAMPLE_SDM_EN
    ,
    output logic                   dac_left,
    output logic                   dac_right
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    stereo_t              mem_q [DEPTH];
    stereo_t              mem_d [DEPTH];
    logic [PTR_W-1:0]     wr_q, wr_d, rd_q, rd_d, rd_nxt;
    logic [LVL_W-1:0]     level_q, level_d;
    stereo_t              head_q, head_d;
    logic                 ovf_q, ovf_d;
    stereo_t              din;
    logic                 full, pop, push;

    always_comb begin
        din.l     = (USE_EXACT != 0) ? xleft  : left;
        din.r     = (USE_EXACT != 0) ? xright : right;
        full      = (level_q == LVL_W'(DEPTH));
        out_valid = (level_q != '0);
        pop       = out_valid && out_ready;
        push      = sample && (!full || pop);
        rd_nxt    = rd_q + 1'b1;

        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q;
        head_d  = head_q;
        ovf_d   = ovf_q;

        if (push) begin
            mem_d[wr_q] = din;
            wr_d        = wr_q + 1'b1;
        end
        if (pop) rd_d = rd_nxt;

        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        // Output register tracks the next head: the following entry after a pop,
        // or the incoming sample when it lands in an (about to be) empty FIFO.
        if (pop) begin
            if (level_q > LVL_W'(1)) head_d = mem_q[rd_nxt];
            else if (push)           head_d = din;
        end else if (!out_valid && push) begin
            head_d = din;
        end

        if (sample && full && !pop) ovf_d = 1'b1;
        else if (ovf_clr)           ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            head_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            head_q  <= head_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_left  = head_q.l;
    assign out_right = head_q.r;
    assign level     = level_q;
    assign ovf       = ovf_q;

`ifdef JT51_SAMPLE_SDM_EN
    stereo_t smp_q, smp_d;

    always_comb begin
        smp_d = sample ? din : smp_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) smp_q <= '0;
        else        smp_q <= smp_d;
    end

    jt51_sdm u_sdm_l (.clk(clk), .rst_n(rst_n), .s(smp_q.l), .dac(dac_left));
    jt51_sdm u_sdm_r (.clk(clk), .rst_n(rst_n), .s(smp_q.r), .dac(dac_right));
`endif

endmodule

// File: tb/tb_jt51_sample_fifo.sv
// Randomised self-checking bench for jt51_sample_fifo against a queue-based reference model.
module tb_jt51_sample_fifo;

    localparam int DEPTH = 4;

    logic        clk = 1'b0, rst_n = 1'b0, sample = 1'b0, out_ready = 1'b0, ovf_clr = 1'b0;
    logic [15:0] left = '0, right = '0, xleft = '0, xright = '0;
    logic [15:0] out_left, out_right;
    logic        out_valid, ovf;
    logic [2:0]  level;
`ifdef JT51_SAMPLE_SDM_EN
    logic        dac_left, dac_right;
`endif

    int checks = 0, errors = 0;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
    } ent_t;

    ent_t mq[$];
    logic m_ovf = 1'b0;

    jt51_sample_fifo #(.DEPTH(DEPTH), .USE_EXACT(0)) dut (
        .clk(clk), .rst_n(rst_n), .sample(sample),
        .left(left), .right(right), .xleft(xleft), .xright(xright),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_left(out_left), .out_right(out_right),
        .level(level), .ovf(ovf), .ovf_clr(ovf_clr)
`ifdef JT51_SAMPLE_SDM_EN
        , .dac_left(dac_left), .dac_right(dac_right)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        bit   pop, full, push;
        ent_t e;
        pop  = (mq.size() != 0) && out_ready;
        full = (mq.size() == DEPTH);
        push = sample && (!full || pop);
        if (sample && full && !pop) m_ovf = 1'b1;
        else if (ovf_clr)           m_ovf = 1'b0;
        if (pop) void'(mq.pop_front());
        if (push) begin
            e.l = left;
            e.r = right;
            mq.push_back(e);
        end
    endtask

    task automatic check_outputs();
        chk("valid", out_valid, mq.size() != 0);
        chk("level", level, mq.size());
        chk("ovf", ovf, m_ovf);
        if (mq.size() != 0) begin
            chk("out_left", out_left, mq[0].l);
            chk("out_right", out_right, mq[0].r);
        end
    endtask

    // Inputs change on negedge, model advances on posedge, outputs checked on the next negedge.
    task automatic cycle(input logic s, input logic [15:0] l, input logic [15:0] r,
                         input logic rdy, input logic clr);
        sample    = s;
        left      = l;
        right     = r;
        xleft     = 16'($urandom);
        xright    = 16'($urandom);
        out_ready = rdy;
        ovf_clr   = clr;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        sample    = 1'b0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_out_left", out_left, 0);
        chk("rst_out_right", out_right, 0);
        rst_n = 1'b1;
    endtask

    task automatic fill(input int n);
        for (int i = 1; i <= n; i++) cycle(1'b1, 16'(i), 16'(i) + 16'h0100, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        do_reset();

        // First capture appears one cycle later and holds without ready.
        cycle(1'b1, 16'h1234, 16'hFEDC, 1'b0, 1'b0);
        chk("t1_left", out_left, 16'h1234);
        chk("t1_right", out_right, 16'hFEDC);
        chk("t1_level", level, 1);
        repeat (10) cycle(1'b0, '0, '0, 1'b0, 1'b0);
        chk("t1_hold", out_left, 16'h1234);

        // Overflow: five samples into four entries, then drain in order.
        do_reset();
        fill(5);
        chk("t2_level", level, 4);
        chk("t2_ovf", ovf, 1);
        for (int i = 1; i <= 4; i++) begin
            chk("t2_drain", out_left, 32'(i));
            cycle(1'b0, '0, '0, 1'b1, 1'b0);
        end
        chk("t2_empty", out_valid, 0);

        // Full with simultaneous push and pop.
        do_reset();
        fill(4);
        cycle(1'b1, 16'h0055, 16'h00AA, 1'b1, 1'b0);
        chk("t3_level", level, 4);
        chk("t3_ovf", ovf, 0);
        chk("t3_head", out_left, 2);
        repeat (3) cycle(1'b0, '0, '0, 1'b1, 1'b0);
        chk("t3_tail", out_left, 16'h0055);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // Overflow flag clear, and set winning over clear.
        do_reset();
        fill(4);
        cycle(1'b1, 16'h7777, 16'h8888, 1'b0, 1'b0);
        chk("t4_set", ovf, 1);
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        chk("t4_clr", ovf, 0);
        cycle(1'b1, 16'h6666, 16'h9999, 1'b0, 1'b1);
        chk("t4_setwins", ovf, 1);

        // Sparse streaming with an always-ready sink.
        do_reset();
        for (int n = 0; n < 100; n++) begin
            cycle(1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b0);
            chk("t5_latency", out_valid, 1);
            for (int k = 0; k < 63; k++) begin
                cycle(1'b0, '0, '0, 1'b1, 1'b0);
                chk("t5_level_le1", level <= 3'd1, 1);
            end
        end

        // Random traffic.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 2) != 0), 16'($urandom), 16'($urandom),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset mid-operation.
        do_reset();
        fill(3);
        chk("t7_level3", level, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_async_valid", out_valid, 0);
        chk("t7_async_level", level, 0);
        mq.delete();
        m_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, '0, '0, 1'b0, 1'b0);

`ifdef JT51_SAMPLE_SDM_EN
        begin
            int ones_l, ones_r;
            do_reset();
            cycle(1'b1, 16'h4000, 16'h8000, 1'b1, 1'b0);
            ones_l = 0;
            ones_r = 0;
            for (int n = 0; n < 4096; n++) begin
                cycle(1'b0, '0, '0, 1'b1, 1'b0);
                ones_l += int'(dac_left);
                ones_r += int'(dac_right);
            end
            chk("sdm_left_density", (ones_l >= 3068) && (ones_l <= 3076), 1);
            chk("sdm_right_zero", ones_r, 0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
